// File: rtl/conv_seq_pkg.sv
// Shared definitions for the frame sequencer: state encoding, frame-size
// defaults and elaboration-time helpers.
package conv_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_RUN    = ST_RUN,
        S_DRAIN  = ST_DRAIN,
        S_DONE   = ST_DONE,
        S_ERR    = ST_ERR
    } seq_state_t;

    localparam int unsigned DEF_WIDTH  = 480;
    localparam int unsigned DEF_HEIGHT = 272;
    localparam int unsigned WIN_TOTAL  = DEF_WIDTH * DEF_HEIGHT;

    function automatic int unsigned win_total(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // True when a cnt_w-bit counter can hold the value total.
    function automatic bit cnt_w_fits(input int unsigned cnt_w, input int unsigned total);
        return (cnt_w >= 32) || (total < (32'd1 << cnt_w));
    endfunction

endpackage

// File: rtl/conv_seq_watchdog.sv
// Loadable down-counting watchdog; expires on the enabled cycle that would
// bring the count to zero, unless a clear arrives in the same cycle.
module conv_seq_watchdog #(
    parameter int unsigned TMO_CYC = 1024,
    localparam int unsigned L_W    = $clog2(TMO_CYC + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [L_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= L_W'(TMO_CYC);
        end else if (i_clr) begin
            r_cnt <= L_W'(TMO_CYC);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - L_W'(1);
        end
    end

    assign o_expire = i_en && !i_clr && (r_cnt == L_W'(1));

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the 3x3 window generator: launches passes,
// counts windows, drains, and flags stalls via an unstalled-cycle watchdog.
//
// state  | meaning
// IDLE   | ready for a start command
// LAUNCH | start asserted to generator, waiting for a non-busy start edge
// RUN    | counting windows, watchdog armed
// DRAIN  | last window seen, waiting DRAIN_CYC unstalled cycles
// DONE   | one-cycle completion, then IDLE
// ERR    | sticky error until start or abort
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned HEIGHT    = DEF_HEIGHT,
    parameter int unsigned CNT_W     = 17,
    parameter int unsigned TMO_CYC   = 1024,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iCmdStart,
    input  logic             iCmdAbort,
    input  logic [7:0]       iFrames,
    input  logic             iMacBusy,
    input  logic             iWinValid,
    output logic             oWinEn,
    output logic             oWinStart,
    output logic             oWinBusy,
    output logic             oWinClr,
    output logic             oReady,
    output logic             oDone,
    output logic             oErr,
    output logic [7:0]       oFrameIdx,
    output logic [CNT_W-1:0] oWinCnt
);

    localparam int unsigned      L_WIN_TOTAL = win_total(WIDTH, HEIGHT);
    localparam logic [CNT_W-1:0] L_LAST_WIN  = CNT_W'(L_WIN_TOTAL - 1);
    localparam int unsigned      L_DRN_W     = $clog2(DRAIN_CYC + 2);

    generate
        if (!cnt_w_fits(CNT_W, L_WIN_TOTAL)) begin : g_bad_cnt_w
            $error("conv_frame_sequencer: CNT_W too narrow for WIDTH*HEIGHT");
        end
    endgenerate

    seq_state_t         r_state, w_next;
    logic [7:0]         r_total, r_frame_idx;
    logic [CNT_W-1:0]   r_win_cnt;
    logic [L_DRN_W-1:0] r_drain;
    logic               r_done, r_clr;
    logic               w_active, w_abort, w_start, w_count, w_next_frame;
    logic               w_last_frame, w_drain_done;
    logic               w_wd_clr, w_wd_en, w_wd_expire;

    // Abort only acts while a pass is in flight; in ERR it has its own path.
    assign w_active     = (r_state == S_LAUNCH) || (r_state == S_RUN) ||
                          (r_state == S_DRAIN)  || (r_state == S_DONE);
    assign w_abort      = iCmdAbort && w_active;
    assign w_start      = iCmdStart && !iCmdAbort &&
                          ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_last_frame = (r_frame_idx == (r_total - 8'd1));
    assign w_drain_done = (r_drain == '0);
    assign w_count      = (r_state == S_RUN) && iWinValid && !iCmdAbort;
    assign w_next_frame = (r_state == S_DRAIN) && !iCmdAbort && !iWinValid &&
                          w_drain_done && !w_last_frame;
    assign w_wd_clr     = (r_state != S_RUN) || iWinValid;
    assign w_wd_en      = (r_state == S_RUN) && !iMacBusy;

    conv_seq_watchdog #(.TMO_CYC(TMO_CYC)) u_watchdog (
        .i_clk    (iClk),
        .i_rst    (iRst),
        .i_clr    (w_wd_clr),
        .i_en     (w_wd_en),
        .o_expire (w_wd_expire)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (w_abort)        w_next = S_IDLE;
                else if (!iMacBusy) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (iWinValid) begin
                    if (r_win_cnt == L_LAST_WIN) w_next = S_DRAIN;
                end else if (w_wd_expire) begin
                    w_next = S_ERR;
                end
            end
            S_DRAIN: begin
                if (w_abort)           w_next = S_IDLE;
                else if (iWinValid)    w_next = S_ERR;
                else if (w_drain_done) w_next = w_last_frame ? S_DONE : S_LAUNCH;
            end
            S_DONE: w_next = S_IDLE;
            S_ERR: begin
                if (iCmdAbort)    w_next = S_IDLE;
                else if (w_start) w_next = S_LAUNCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_clr       <= 1'b0;
            r_total     <= 8'd1;
            r_frame_idx <= 8'd0;
            r_win_cnt   <= '0;
            r_drain     <= L_DRN_W'(DRAIN_CYC);
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE);
            r_clr   <= w_abort || ((w_next == S_ERR) && (r_state != S_ERR));
            if (w_start) begin
                r_total     <= (iFrames == 8'd0) ? 8'd1 : iFrames;
                r_frame_idx <= 8'd0;
                r_win_cnt   <= '0;
            end else if (w_next_frame) begin
                r_frame_idx <= r_frame_idx + 8'd1;
                r_win_cnt   <= '0;
            end else if (w_count) begin
                r_win_cnt <= r_win_cnt + CNT_W'(1);
            end
            // Reloaded outside DRAIN so every drain phase starts full.
            if (r_state != S_DRAIN) begin
                r_drain <= L_DRN_W'(DRAIN_CYC);
            end else if (!iMacBusy && !w_drain_done) begin
                r_drain <= r_drain - L_DRN_W'(1);
            end
        end
    end

    assign oReady    = (r_state == S_IDLE);
    assign oWinEn    = (r_state == S_LAUNCH) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign oWinStart = (r_state == S_LAUNCH);
    assign oErr      = (r_state == S_ERR);
    assign oWinBusy  = iMacBusy;
    assign oDone     = r_done;
    assign oWinClr   = r_clr;
    assign oFrameIdx = r_frame_idx;
    assign oWinCnt   = r_win_cnt;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on a 4x3 frame with a small
// behavioural window-generator model feeding iWinValid.
module tb_conv_frame_sequencer;

    localparam int unsigned CNT_W = 17;

    logic             iClk, iRst, iCmdStart, iCmdAbort, iMacBusy, iWinValid;
    logic [7:0]       iFrames;
    logic             oWinEn, oWinStart, oWinBusy, oWinClr, oReady, oDone, oErr;
    logic [7:0]       oFrameIdx;
    logic [CNT_W-1:0] oWinCnt;

    conv_frame_sequencer #(
        .WIDTH(4), .HEIGHT(3), .CNT_W(CNT_W), .TMO_CYC(8), .DRAIN_CYC(2)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iCmdStart(iCmdStart), .iCmdAbort(iCmdAbort),
        .iFrames(iFrames), .iMacBusy(iMacBusy), .iWinValid(iWinValid),
        .oWinEn(oWinEn), .oWinStart(oWinStart), .oWinBusy(oWinBusy),
        .oWinClr(oWinClr), .oReady(oReady), .oDone(oDone), .oErr(oErr),
        .oFrameIdx(oFrameIdx), .oWinCnt(oWinCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Generator model: reloads on the start edge, emits while enabled and not busy.
    int   gen_limit = 12;
    int   gen_left  = 0;
    logic inj_valid = 1'b0;
    logic model_valid;
    assign model_valid = oWinEn && !oWinStart && !iMacBusy && (gen_left > 0);
    assign iWinValid   = model_valid | inj_valid;

    always @(posedge iClk) begin
        if (oWinStart && !iMacBusy) gen_left <= gen_limit;
        else if (model_valid)       gen_left <= gen_left - 1;
    end

    int   n_done = 0, n_clr = 0, n_err = 0, n_launch = 0;
    logic mon_prev_start = 1'b0;
    always @(posedge iClk) begin
        if (oDone)   n_done++;
        if (oWinClr) n_clr++;
        if (oErr)    n_err++;
        if (oWinStart && !mon_prev_start) n_launch++;
        mon_prev_start = oWinStart;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_cnt(input string tag, input int target, input int max_cyc);
        int k = 0;
        while ((oWinCnt != CNT_W'(target)) && (k < max_cyc)) begin
            cyc();
            k++;
        end
        chk(tag, 32'(oWinCnt), 32'(target));
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int k = 0;
        while (!oDone && (k < max_cyc)) begin
            cyc();
            k++;
        end
        chk(tag, 32'(oDone), 32'd1);
    endtask

    task automatic start_cmd(input logic [7:0] frames);
        iFrames   = frames;
        iCmdStart = 1'b1;
        cyc();
        iCmdStart = 1'b0;
    endtask

    initial begin
        int   s_done, s_clr, s_err, s_launch, nf;
        int   fi[3];
        logic pst, en_ok;

        iRst = 1'b1; iCmdStart = 1'b0; iCmdAbort = 1'b0; iFrames = 8'd1; iMacBusy = 1'b0;
        #11;
        chk("rst_ready", 32'(oReady), 32'd1);
        chk("rst_en", 32'(oWinEn), 32'd0);
        chk("rst_start", 32'(oWinStart), 32'd0);
        chk("rst_clr_done_err", {29'd0, oWinClr, oDone, oErr}, 32'd0);
        chk("rst_idx_cnt", 32'(oFrameIdx) + 32'(oWinCnt), 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        cyc();

        // Single frame, no stall
        gen_limit = 12;
        start_cmd(8'd1);
        chk("t1_launch_latency", 32'(oWinStart), 32'd1);
        chk("t1_not_ready", 32'(oReady), 32'd0);
        iMacBusy = 1'b1;
        chk("t1_busy_passthru", 32'(oWinBusy), 32'd1);
        iMacBusy = 1'b0;
        wait_cnt("t1_cnt12", 12, 40);
        cyc();
        chk("t1_done_early1", 32'(oDone), 32'd0);
        cyc();
        chk("t1_done_early2", 32'(oDone), 32'd0);
        cyc();
        chk("t1_done_at3", 32'(oDone), 32'd1);
        cyc();
        chk("t1_done_one_cycle", 32'(oDone), 32'd0);
        chk("t1_ready_after", 32'(oReady), 32'd1);
        chk("t1_cnt_hold", 32'(oWinCnt), 32'd12);

        // Three frames with random back-pressure
        s_done = n_done; s_err = n_err; s_launch = n_launch;
        fi[0] = 255; fi[1] = 255; fi[2] = 255;
        start_cmd(8'd3);
        fi[0] = 32'(oFrameIdx); nf = 1; pst = oWinStart;
        for (int k = 0; k < 2000; k++) begin
            iMacBusy = ($urandom_range(0, 99) < 30);
            cyc();
            if (oWinStart && !pst && (nf < 3)) begin
                fi[nf] = 32'(oFrameIdx);
                nf++;
            end
            pst = oWinStart;
            if (oDone) break;
        end
        chk("t2_done_seen", 32'(oDone), 32'd1);
        iMacBusy = 1'b0;
        cyc();
        chk("t2_launches", 32'(n_launch - s_launch), 32'd3);
        chk("t2_idx0", 32'(fi[0]), 32'd0);
        chk("t2_idx1", 32'(fi[1]), 32'd1);
        chk("t2_idx2", 32'(fi[2]), 32'd2);
        chk("t2_one_done", 32'(n_done - s_done), 32'd1);
        chk("t2_no_err", 32'(n_err - s_err), 32'd0);
        chk("t2_final_idx", 32'(oFrameIdx), 32'd2);

        // Watchdog: five windows then silence
        gen_limit = 5;
        s_clr = n_clr;
        start_cmd(8'd1);
        wait_cnt("t3_cnt5", 5, 40);
        for (int k = 0; k < 7; k++) cyc();
        chk("t3_no_err_at7", 32'(oErr), 32'd0);
        chk("t3_en_at7", 32'(oWinEn), 32'd1);
        cyc();
        chk("t3_err_at8", 32'(oErr), 32'd1);
        chk("t3_en_off", 32'(oWinEn), 32'd0);
        for (int k = 0; k < 3; k++) cyc();
        chk("t3_err_sticky", 32'(oErr), 32'd1);
        chk("t3_clr_once", 32'(n_clr - s_clr), 32'd1);
        iCmdAbort = 1'b1;
        cyc();
        iCmdAbort = 1'b0;
        chk("t3_abort_ready", 32'(oReady), 32'd1);
        chk("t3_abort_err_clr", 32'(oErr), 32'd0);

        // Long stall in RUN never times out
        gen_limit = 12;
        s_err = n_err;
        start_cmd(8'd1);
        wait_cnt("t4_cnt3", 3, 40);
        iMacBusy = 1'b1;
        en_ok = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (!oWinEn || oErr) en_ok = 1'b0;
        end
        chk("t4_en_held", 32'(en_ok), 32'd1);
        chk("t4_cnt_frozen", 32'(oWinCnt), 32'd3);
        iMacBusy = 1'b0;
        wait_done("t4_done", 60);
        chk("t4_cnt12", 32'(oWinCnt), 32'd12);
        chk("t4_no_err", 32'(n_err - s_err), 32'd0);
        cyc();

        // Abort + start + valid in the same cycle
        s_done = n_done; s_clr = n_clr;
        start_cmd(8'd1);
        wait_cnt("t5_cnt6", 6, 40);
        iCmdAbort = 1'b1; iCmdStart = 1'b1; inj_valid = 1'b1;
        cyc();
        iCmdAbort = 1'b0; iCmdStart = 1'b0; inj_valid = 1'b0;
        chk("t5_idle_next", 32'(oReady), 32'd1);
        chk("t5_cnt_hold6", 32'(oWinCnt), 32'd6);
        chk("t5_en_off", 32'(oWinEn), 32'd0);
        for (int k = 0; k < 3; k++) cyc();
        chk("t5_clr_once", 32'(n_clr - s_clr), 32'd1);
        chk("t5_no_done", 32'(n_done - s_done), 32'd0);
        chk("t5_still_idle", 32'(oReady), 32'd1);

        // iFrames=0 runs exactly one frame
        s_done = n_done; s_launch = n_launch;
        start_cmd(8'd0);
        wait_done("t6_done", 60);
        cyc();
        chk("t6_one_launch", 32'(n_launch - s_launch), 32'd1);
        chk("t6_one_done", 32'(n_done - s_done), 32'd1);
        chk("t6_idx0", 32'(oFrameIdx), 32'd0);

        // Stray valid during DRAIN
        s_done = n_done; s_clr = n_clr;
        start_cmd(8'd1);
        wait_cnt("t7_cnt12", 12, 40);
        inj_valid = 1'b1;
        cyc();
        inj_valid = 1'b0;
        chk("t7_err", 32'(oErr), 32'd1);
        cyc(); cyc();
        chk("t7_clr_once", 32'(n_clr - s_clr), 32'd1);
        chk("t7_no_done", 32'(n_done - s_done), 32'd0);
        start_cmd(8'd1);
        chk("t7_restart_err_clr", 32'(oErr), 32'd0);
        chk("t7_restart_launch", 32'(oWinStart), 32'd1);
        chk("t7_restart_cnt0", 32'(oWinCnt), 32'd0);
        wait_done("t7_done", 60);
        cyc();

        // Asynchronous reset mid-frame
        s_clr = n_clr;
        start_cmd(8'd1);
        wait_cnt("t8_cnt2", 2, 40);
        #2;
        iRst = 1'b1;
        #1;
        chk("t8_async_ready", 32'(oReady), 32'd1);
        chk("t8_async_cnt0", 32'(oWinCnt), 32'd0);
        chk("t8_async_en0", 32'(oWinEn), 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        cyc(); cyc();
        chk("t8_no_clr", 32'(n_clr - s_clr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller for the RGB888 3x3 window generator. It sits between the host command interface and the window generator, and sequences one or more full-frame passes. For each pass it:
- issues the start pulse,
- gates the window generator's enable and busy inputs,
- counts emitted windows and drains the generator back to idle.

It reports completion, and detects stalls with a watchdog that only counts unstalled cycles.

## Interface
Parameters:
- WIDTH, 480, frame width in pixels
- HEIGHT, 272, frame height in pixels
- CNT_W, 17, window counter width; must hold WIDTH*HEIGHT
- TMO_CYC, 1024, unstalled cycles without a window before the watchdog fires
- DRAIN_CYC, 2, unstalled enabled cycles after the last window of a frame

Ports (clock and reset first):
- iClk  in  1  single clock; all logic on rising edge
- iRst  in  1  reset, asynchronous, active-high
- iCmdStart  in  1  one-cycle start command
- iCmdAbort  in  1  one-cycle abort command
- iFrames  in  8  number of frame passes, sampled at start; 0 is treated as 1
- iMacBusy  in  1  downstream MAC back-pressure
- iWinValid  in  1  window-valid from the generator (already qualified by enable and not-busy)
- oWinEn  out  1  enable to the generator
- oWinStart  out  1  start to the generator
- oWinBusy  out  1  busy to the generator; combinational copy of iMacBusy
- oWinClr  out  1  one-cycle request; top level clears the generator state from it
- oReady  out  1  sequencer is idle and accepts iCmdStart
- oDone  out  1  one-cycle pulse when all frames complete
- oErr  out  1  sticky error flag
- oFrameIdx  out  8  current frame index, 0-based
- oWinCnt  out  CNT_W  windows counted in the current frame

## Operation
The state machine has states IDLE, LAUNCH, RUN, DRAIN, DONE and ERR.

- **IDLE**
  - oReady=1.
  - On iCmdStart: latch frame total (0 becomes 1), clear oFrameIdx and oWinCnt, go to LAUNCH.
- **LAUNCH**
  - oWinEn=1 and oWinStart=1.
  - Holds while iMacBusy=1.
  - Goes to RUN on the first cycle with iMacBusy=0; that cycle is the generator's start edge.
- **RUN**
  - oWinEn=1.
  - Each iWinValid increments oWinCnt.
  - The valid that brings oWinCnt to WIDTH*HEIGHT goes to DRAIN.
- **DRAIN**
  - oWinEn=1; counts DRAIN_CYC cycles with iMacBusy=0.
  - When the count completes:
    - if oFrameIdx equals total-1, go to DONE;
    - otherwise oFrameIdx+1, oWinCnt=0, go to LAUNCH.
  - An iWinValid in DRAIN goes to ERR.
- **DONE**
  - oDone=1 for one cycle, then IDLE.
  - oWinCnt and oFrameIdx hold their final values until the next start.
- **ERR**
  - oErr=1 (sticky), oWinEn=0.
  - On iCmdStart: clear oErr and behave as the IDLE start.
  - On iCmdAbort: clear oErr and go to IDLE.

Watchdog:
- Active in RUN only.
- Counts cycles with iMacBusy=0; clears on iWinValid and on RUN entry.
- Reaching TMO_CYC goes to ERR.

Abort:
- iCmdAbort in any state other than IDLE/ERR goes to IDLE next cycle, with no oDone.

oWinClr:
- One-cycle pulse on the cycle after entering IDLE via abort, and on the cycle after entering ERR.

Priorities:
- Abort beats start, beats valid, beats watchdog.
- iWinValid and watchdog expiry in the same cycle: the valid wins and the watchdog clears.
- iCmdStart outside IDLE/ERR is ignored.

## Timing
- Reset values: state IDLE, oReady=1, oWinEn=0, oWinStart=0, oWinClr=0, oDone=0, oErr=0, oFrameIdx=0, oWinCnt=0.
- Reset mid-frame returns to IDLE immediately and asynchronously; oWinClr is not pulsed, because the generator shares reset.
- Output sourcing:
  - oWinEn, oWinStart, oReady and oErr are decoded from the registered state.
  - oWinBusy is combinational.
  - oDone and oWinClr are registered pulses.
- Latency:
  - iCmdStart to LAUNCH: 1 cycle.
  - Last iWinValid to DONE: DRAIN_CYC+1 cycles with no stall.
- oWinCnt updates on the edge after the iWinValid it counts.

## Structure
- Package conv_seq_pkg holds:
  - the state encoding (3-bit localparams);
  - WIN_TOTAL = WIDTH*HEIGHT;
  - a helper constant for the counter width check.
- One sub-module, conv_seq_watchdog: a loadable cycle counter with clear, count-enable (RUN && !iMacBusy) and expire outputs, of width $clog2(TMO_CYC+1).
- DRAIN counting reuses a small local counter.

## Test plan
The bench uses WIDTH=4, HEIGHT=3, TMO_CYC=8, DRAIN_CYC=2, and drives iWinValid from a model of the window generator.

- **Single frame.** Stimulus: iFrames=1, start, 12 valids, no stall. Required: oWinCnt reaches 12; oDone pulses exactly 2+1 cycles after the 12th valid; oReady=1 afterwards.
- **Three frames with stalls.** Stimulus: iFrames=3, iMacBusy randomly high 30%. Required: three LAUNCH entries; oFrameIdx steps 0, 1, 2; one oDone; no oErr.
- **Watchdog.** Stimulus: start, 5 valids, then silence with iMacBusy=0. Required: ERR 8 cycles after the 5th valid; oErr=1; oWinClr pulses once.
- **Stall never times out.** Stimulus: iMacBusy held high for 100 cycles in RUN. Required: no ERR; oWinEn stays 1; the frame completes after busy drops.
- **Abort priority.** Stimulus: abort at window 6, asserted in the same cycle as iCmdStart and iWinValid. Required: IDLE next cycle; oWinClr pulses; oDone stays 0; oWinCnt holds 6.
- **Degenerate inputs.** Stimulus: iFrames=0; and a valid injected during DRAIN. Required: exactly one frame is run; the injected valid sends the block to ERR.
